// File: rtl/llsc_reservation_monitor.sv
// Multi-channel LL/SC reservation monitor: one granule reservation per channel,
// cross-channel store snoop, per-channel flush, registered SC verdict, optional timeout.
module llsc_reservation_monitor #(
    parameter  int NUM_CH      = 2,
    parameter  int ADDR_W      = 32,
    parameter  int GRAN_LOG2   = 4,
    parameter  int TIMEOUT_CYC = 0,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        flush_i,
    input  logic [NUM_CH-1:0]        ll_req_i,
    input  logic [NUM_CH-1:0]        sc_req_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
    input  logic                     st_valid_i,
    input  logic [CH_W-1:0]          st_ch_i,
    input  logic [ADDR_W-1:0]        st_addr_i,
    output logic [NUM_CH-1:0]        llbit_o,
    output logic [NUM_CH-1:0]        sc_done_o,
    output logic [NUM_CH-1:0]        sc_ok_o
);

    localparam int GRAN_W = ADDR_W - GRAN_LOG2;

    logic [GRAN_W-1:0] st_gran;
    assign st_gran = st_addr_i[ADDR_W-1:GRAN_LOG2];

    if (GRAN_LOG2 > 0) begin : g_st_low
        logic unused_st_low;
        assign unused_st_low = ^st_addr_i[GRAN_LOG2-1:0];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [CH_W-1:0] CH_IDX = CH_W'(c);

        logic [GRAN_W-1:0] ch_gran;
        logic [GRAN_W-1:0] gran_q, gran_d;
        logic              valid_q, valid_d;
        logic              done_q, done_d;
        logic              ok_q, ok_d;
        logic              snoop_hit;
        logic              ll_take;
        logic              timeout;

        assign ch_gran = ch_addr_i[c*ADDR_W+GRAN_LOG2 +: GRAN_W];

        if (GRAN_LOG2 > 0) begin : g_ch_low
            logic unused_ch_low;
            assign unused_ch_low = ^ch_addr_i[c*ADDR_W +: GRAN_LOG2];
        end

        // st_ch_i values beyond NUM_CH-1 never equal CH_IDX, so they count as foreign
        assign snoop_hit = st_valid_i && (st_ch_i != CH_IDX) && (st_gran == gran_q) && valid_q;
        assign ll_take   = ll_req_i[c] && !flush_i[c];

        always_comb begin
            done_d  = sc_req_i[c] && !flush_i[c];
            ok_d    = done_d && valid_q && (ch_gran == gran_q);
            valid_d = valid_q;
            gran_d  = gran_q;
            if (flush_i[c]) begin
                valid_d = 1'b0;
            end else if (ll_req_i[c]) begin
                valid_d = 1'b1;
                gran_d  = ch_gran;
            end else if (sc_req_i[c] || snoop_hit || timeout) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                gran_q  <= '0;
                done_q  <= 1'b0;
                ok_q    <= 1'b0;
            end else begin
                valid_q <= valid_d;
                gran_q  <= gran_d;
                done_q  <= done_d;
                ok_q    <= ok_d;
            end
        end

        if (TIMEOUT_CYC > 0) begin : g_age
            localparam int AGE_W = $clog2(TIMEOUT_CYC + 1);

            logic [AGE_W-1:0] age_q, age_d;

            always_comb begin
                age_d = age_q;
                if (!valid_d || ll_take) begin
                    age_d = '0;
                end else if (age_q != '1) begin
                    age_d = age_q + AGE_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    age_q <= '0;
                end else begin
                    age_q <= age_d;
                end
            end

            // age counts edges since the LL, so TIMEOUT_CYC-1 marks the last live cycle
            assign timeout = valid_q && (age_q == AGE_W'(TIMEOUT_CYC - 1));
        end else begin : g_no_age
            assign timeout = 1'b0;
        end

        assign llbit_o[c]   = valid_q;
        assign sc_done_o[c] = done_q;
        assign sc_ok_o[c]   = ok_q;
    end

endmodule

// File: tb/tb_llsc_reservation_monitor.sv
// Directed checks on a 2-channel instance with timeout, plus a random run of a
// 4-channel instance against a behavioural reservation model.
module tb_llsc_reservation_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: directed ----------------
    logic        a_rst;
    logic [1:0]  a_flush, a_ll, a_sc;
    logic [63:0] a_addr;
    logic        a_st_valid;
    logic [0:0]  a_st_ch;
    logic [31:0] a_st_addr;
    logic [1:0]  a_llbit, a_done, a_ok;

    llsc_reservation_monitor #(
        .NUM_CH(2), .ADDR_W(32), .GRAN_LOG2(4), .TIMEOUT_CYC(4)
    ) u_dut_a (
        .clk(clk), .rst(a_rst), .flush_i(a_flush), .ll_req_i(a_ll), .sc_req_i(a_sc),
        .ch_addr_i(a_addr), .st_valid_i(a_st_valid), .st_ch_i(a_st_ch),
        .st_addr_i(a_st_addr), .llbit_o(a_llbit), .sc_done_o(a_done), .sc_ok_o(a_ok)
    );

    task automatic a_idle();
        a_rst = 1'b0; a_flush = '0; a_ll = '0; a_sc = '0;
        a_st_valid = 1'b0; a_st_ch = '0; a_st_addr = '0;
    endtask

    // ---------------- instance B: random vs model ----------------
    localparam int BN  = 4;
    localparam int BTO = 6;

    logic          b_rst;
    logic [BN-1:0] b_flush, b_ll, b_sc;
    logic [127:0]  b_addr;
    logic          b_st_valid;
    logic [1:0]    b_st_ch;
    logic [31:0]   b_st_addr;
    logic [BN-1:0] b_llbit, b_done, b_ok;

    llsc_reservation_monitor #(
        .NUM_CH(BN), .ADDR_W(32), .GRAN_LOG2(2), .TIMEOUT_CYC(BTO)
    ) u_dut_b (
        .clk(clk), .rst(b_rst), .flush_i(b_flush), .ll_req_i(b_ll), .sc_req_i(b_sc),
        .ch_addr_i(b_addr), .st_valid_i(b_st_valid), .st_ch_i(b_st_ch),
        .st_addr_i(b_st_addr), .llbit_o(b_llbit), .sc_done_o(b_done), .sc_ok_o(b_ok)
    );

    logic [BN-1:0] m_valid, m_done, m_ok;
    logic [29:0]   m_gran [BN];
    int            m_age  [BN];

    function automatic logic [31:0] rand_addr();
        return 32'h100 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
    endfunction

    initial begin
        a_idle();
        a_addr = '0;
        b_rst = 1'b1; b_flush = '0; b_ll = '0; b_sc = '0; b_addr = '0;
        b_st_valid = 1'b0; b_st_ch = '0; b_st_addr = '0;

        // T1: reset dominates everything
        a_rst = 1'b1; a_flush = 2'b11; a_ll = 2'b11; a_sc = 2'b11;
        a_st_valid = 1'b1; a_addr = {32'h1000, 32'h1000};
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t1_llbit", 32'(a_llbit), 32'h0);
            check("t1_done", 32'(a_done), 32'h0);
            check("t1_ok", 32'(a_ok), 32'h0);
        end
        a_idle();

        // T2: LL/SC pass in same granule, then fail on neighbouring granule
        a_ll = 2'b01; a_addr[31:0] = 32'h1000;
        tick();
        check("t2_llbit_set", 32'(a_llbit), 32'h1);
        a_ll = '0; a_sc = 2'b01; a_addr[31:0] = 32'h100C;
        tick();
        check("t2_done", 32'(a_done), 32'h1);
        check("t2_ok", 32'(a_ok), 32'h1);
        check("t2_llbit_consumed", 32'(a_llbit), 32'h0);
        a_sc = '0;
        tick();
        check("t2_done_pulse", 32'(a_done), 32'h0);
        a_ll = 2'b01; a_addr[31:0] = 32'h1000;
        tick();
        a_ll = '0; a_sc = 2'b01; a_addr[31:0] = 32'h1010;
        tick();
        check("t2_fail_done", 32'(a_done), 32'h1);
        check("t2_fail_ok", 32'(a_ok), 32'h0);
        a_idle();

        // T3: foreign store clears the other channel only
        a_ll = 2'b11; a_addr = {32'h2000, 32'h2000};
        tick();
        check("t3_both_set", 32'(a_llbit), 32'h3);
        a_ll = '0; a_st_valid = 1'b1; a_st_ch = 1'b1; a_st_addr = 32'h2004;
        tick();
        check("t3_snoop", 32'(a_llbit), 32'h2);
        a_st_valid = 1'b0; a_sc = 2'b11;
        tick();
        check("t3_done", 32'(a_done), 32'h3);
        check("t3_ok", 32'(a_ok), 32'h2);
        check("t3_llbit_after", 32'(a_llbit), 32'h0);
        a_idle();

        // T4: flush beats LL; LL beats same-cycle snoop; flush kills a verdict
        a_ll = 2'b10; a_addr[63:32] = 32'h3000;
        tick();
        a_flush = 2'b01; a_ll = 2'b11; a_addr = {32'h3000, 32'h4000};
        a_st_valid = 1'b1; a_st_ch = 1'b0; a_st_addr = 32'h3008;
        tick();
        check("t4_prio", 32'(a_llbit), 32'h2);
        a_idle();
        a_flush = 2'b10; a_sc = 2'b10;
        tick();
        check("t4_flush_done", 32'(a_done), 32'h0);
        check("t4_flush_llbit", 32'(a_llbit), 32'h0);
        a_idle();

        // own store keeps reservation; re-LL moves it
        a_ll = 2'b01; a_addr[31:0] = 32'h5000;
        tick();
        a_ll = '0; a_st_valid = 1'b1; a_st_ch = 1'b0; a_st_addr = 32'h5000;
        tick();
        check("own_store", 32'(a_llbit), 32'h1);
        a_st_valid = 1'b0; a_ll = 2'b01; a_addr[31:0] = 32'h6000;
        tick();
        a_ll = '0; a_sc = 2'b01; a_addr[31:0] = 32'h5000;
        tick();
        check("relink_ok", 32'(a_ok), 32'h0);
        a_idle();

        // T5: timeout, last live cycle still passes
        a_ll = 2'b01; a_addr[31:0] = 32'h7000;
        tick();
        a_ll = '0;
        check("t5_cyc1", 32'(a_llbit), 32'h1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("t5_live", 32'(a_llbit), 32'h1);
        end
        tick();
        check("t5_expired", 32'(a_llbit), 32'h0);
        a_sc = 2'b01;
        tick();
        check("t5_sc_done", 32'(a_done), 32'h1);
        check("t5_sc_ok", 32'(a_ok), 32'h0);
        a_idle();
        a_ll = 2'b01;
        tick();
        a_ll = '0;
        tick(); tick(); tick();
        a_sc = 2'b01;
        tick();
        check("t5_edge_ok", 32'(a_ok), 32'h1);
        a_idle();

        // reset mid-operation discards the pending verdict
        a_ll = 2'b01;
        tick();
        a_ll = '0; a_sc = 2'b01; a_rst = 1'b1;
        tick();
        check("rst_mid_done", 32'(a_done), 32'h0);
        check("rst_mid_llbit", 32'(a_llbit), 32'h0);
        a_idle();

        // T6: random run of instance B
        tick();
        m_valid = '0; m_done = '0; m_ok = '0;
        for (int c = 0; c < BN; c++) begin
            m_gran[c] = '0;
            m_age[c]  = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic [BN-1:0] n_valid, n_done, n_ok;
            logic [29:0]   g, sg;
            b_rst      = ($urandom_range(0, 499) == 0);
            b_st_valid = ($urandom_range(0, 2) == 0);
            b_st_ch    = 2'($urandom_range(0, 3));
            b_st_addr  = rand_addr();
            for (int c = 0; c < BN; c++) begin
                b_flush[c] = ($urandom_range(0, 29) == 0);
                b_ll[c]    = ($urandom_range(0, 3) == 0);
                b_sc[c]    = ($urandom_range(0, 4) == 0);
                b_addr[c*32 +: 32] = rand_addr();
            end
            sg = b_st_addr[31:2];
            for (int c = 0; c < BN; c++) begin
                g = b_addr[c*32+2 +: 30];
                n_done[c] = !b_rst && !b_flush[c] && b_sc[c];
                n_ok[c]   = n_done[c] && m_valid[c] && (g == m_gran[c]);
                if (b_rst) begin
                    n_valid[c] = 1'b0; m_gran[c] = '0; m_age[c] = 0;
                end else if (b_flush[c]) begin
                    n_valid[c] = 1'b0; m_age[c] = 0;
                end else if (b_ll[c]) begin
                    n_valid[c] = 1'b1; m_gran[c] = g; m_age[c] = 0;
                end else if (b_sc[c]
                             || (b_st_valid && int'(b_st_ch) != c && sg == m_gran[c] && m_valid[c])
                             || (m_valid[c] && m_age[c] == BTO - 1)) begin
                    n_valid[c] = 1'b0; m_age[c] = 0;
                end else begin
                    n_valid[c] = m_valid[c];
                    m_age[c]   = m_valid[c] ? m_age[c] + 1 : 0;
                end
            end
            tick();
            m_valid = n_valid; m_done = n_done; m_ok = n_ok;
            check("t6_llbit", 32'(b_llbit), 32'(m_valid));
            check("t6_done", 32'(b_done), 32'(m_done));
            check("t6_ok", 32'(b_ok), 32'(m_ok));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
